spi_reg_bridge: RTL and testbench



---
 rtl/spi_reg_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Converts single register read/write requests into one SPI frame for a downstream
//   SPI master, then turns the returned frame into a register response. Only one
//   transaction is in flight at a time. If the downstream side never answers, the
//   bridge reports a timeout. It then drains the late reply so that the reply cannot be
//   mistaken for the answer to the next request.
//
// Ports
//   clk_i, rst_n_i        : clock, asynchronous active-low reset (sync deassert upstream)
//   req_*                 : register request channel (valid/ready, write, addr, wdata)
//   rsp_*                 : register response channel (valid/ready, rdata, err, timeout)
//   spi_wrdata_*          : outgoing SPI frame (valid/ready, length in bits, frame bits)
//   spi_rddata_*          : returned SPI frame (valid/ready, per-bit valid mask, bits)
//
// Frame layout (MSB first, right-aligned in spi_wrdata_o):
//   [FRAME_LEN-1] = 1 for read, [.. -: ADDR_WIDTH] = addr, [DATA_WIDTH-1:0] = wdata / 0
module spi_reg_bridge #(
  parameter int unsigned ADDR_WIDTH      = 6,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned MAX_DATA_LENGTH = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  localparam int unsigned LEN_WIDTH      = $clog2(MAX_DATA_LENGTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  // register request
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [DATA_WIDTH-1:0]      req_wdata_i,
  // register response
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_WIDTH-1:0]      rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic                       rsp_timeout_o,
  // SPI frame out
  output logic                       spi_wrdata_valid_o,
  input  logic                       spi_wrdata_ready_i,
  output logic [LEN_WIDTH-1:0]       spi_wrdata_len_o,
  output logic [MAX_DATA_LENGTH-1:0] spi_wrdata_o,
  // SPI frame in
  input  logic                       spi_rddata_valid_i,
  output logic                       spi_rddata_ready_o,
  input  logic [MAX_DATA_LENGTH-1:0] spi_rddata_mask_i,
  input  logic [MAX_DATA_LENGTH-1:0] spi_rddata_i
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  // A zero-width counter is not legal; with the timeout disabled the counter is unused.
  localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] FRAME_LEN_VAL = LEN_WIDTH'(FRAME_LEN);

  if (FRAME_LEN > MAX_DATA_LENGTH - 1) begin : g_frame_too_long
    $error("spi_reg_bridge: 1+ADDR_WIDTH+DATA_WIDTH must be <= MAX_DATA_LENGTH-1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StDrain
  } state_e;

  state_e                  r_state;
  logic                    r_req_ready;
  // Read flag and zeroed-for-read data are captured directly, so the frame is a pure
  // wiring of registers and is all-zero while in reset.
  logic                    r_read;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_wr_valid;
  logic [LEN_WIDTH-1:0]    r_wr_len;
  logic                    r_rd_ready;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;

  logic [MAX_DATA_LENGTH-1:0] w_frame;
  logic                       w_mask_err;
  logic                       w_timeout_hit;
  logic                       w_unused_bits;

  always_comb begin
    w_frame                              = '0;
    w_frame[FRAME_LEN-1]                 = r_read;
    w_frame[FRAME_LEN-2 -: ADDR_WIDTH]   = r_addr;
    w_frame[DATA_WIDTH-1:0]              = r_wdata;
  end

  // Any frame bit the SPI master could not clock back marks the response as bad.
  assign w_mask_err    = ~&spi_rddata_mask_i[FRAME_LEN-1:0];
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  // Bits beyond the frame / data field carry no meaning for this bridge.
  assign w_unused_bits = ^{spi_rddata_i[MAX_DATA_LENGTH-1:DATA_WIDTH],
                           spi_rddata_mask_i[MAX_DATA_LENGTH-1:FRAME_LEN]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= StIdle;
      r_req_ready   <= 1'b0;
      r_read        <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wr_valid    <= 1'b0;
      r_wr_len      <= '0;
      r_rd_ready    <= 1'b0;
      r_cnt         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Ready is held low on the first cycle out of reset, so gate on the register.
          r_req_ready <= 1'b1;
          if (req_valid_i && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_read      <= ~req_write_i;
            r_addr      <= req_addr_i;
            r_wdata     <= req_write_i ? req_wdata_i : '0;
            r_wr_len    <= FRAME_LEN_VAL;
            r_wr_valid  <= 1'b1;
            r_state     <= StIssue;
          end
        end

        StIssue: begin
          if (spi_wrdata_ready_i) begin
            r_wr_valid <= 1'b0;
            r_rd_ready <= 1'b1;
            r_cnt      <= '0;
            r_state    <= StWait;
          end
        end

        StWait: begin
          // Real data beats a timeout that lands on the same cycle.
          if (spi_rddata_valid_i) begin
            r_rd_ready    <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= r_read ? spi_rddata_i[DATA_WIDTH-1:0] : '0;
            r_rsp_err     <= w_mask_err;
            r_rsp_timeout <= 1'b0;
            r_state       <= StResp;
          end else if (w_timeout_hit) begin
            r_rd_ready    <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_state       <= StResp;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end

        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            // After a timeout the SPI master still owes us a frame; swallow it first.
            if (r_rsp_timeout) begin
              r_rd_ready <= 1'b1;
              r_state    <= StDrain;
            end else begin
              r_req_ready <= 1'b1;
              r_state     <= StIdle;
            end
          end
        end

        StDrain: begin
          if (spi_rddata_valid_i) begin
            r_rd_ready  <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end

        default: begin
          r_req_ready <= 1'b0;
          r_wr_valid  <= 1'b0;
          r_rd_ready  <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o        = r_req_ready;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_rdata_o        = r_rsp_rdata;
  assign rsp_err_o          = r_rsp_err;
  assign rsp_timeout_o      = r_rsp_timeout;
  assign spi_wrdata_valid_o = r_wr_valid;
  assign spi_wrdata_len_o   = r_wr_len;
  assign spi_wrdata_o       = w_frame;
  assign spi_rddata_ready_o = r_rd_ready;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives register requests, plays the downstream SPI
// master, and checks frames and responses against expectations queued at stimulus time.
module tb_spi_reg_bridge;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned ML = 16;
  localparam int unsigned TO = 8;
  localparam int unsigned LW = 4;

  logic          clk;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_write_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic          spi_wrdata_valid_o;
  logic          spi_wrdata_ready_i;
  logic [LW-1:0] spi_wrdata_len_o;
  logic [ML-1:0] spi_wrdata_o;
  logic          spi_rddata_valid_i;
  logic          spi_rddata_ready_o;
  logic [ML-1:0] spi_rddata_mask_i;
  logic [ML-1:0] spi_rddata_i;

  spi_reg_bridge #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_DATA_LENGTH (ML),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_write_i        (req_write_i),
    .req_addr_i         (req_addr_i),
    .req_wdata_i        (req_wdata_i),
    .rsp_valid_o        (rsp_valid_o),
    .rsp_ready_i        (rsp_ready_i),
    .rsp_rdata_o        (rsp_rdata_o),
    .rsp_err_o          (rsp_err_o),
    .rsp_timeout_o      (rsp_timeout_o),
    .spi_wrdata_valid_o (spi_wrdata_valid_o),
    .spi_wrdata_ready_i (spi_wrdata_ready_i),
    .spi_wrdata_len_o   (spi_wrdata_len_o),
    .spi_wrdata_o       (spi_wrdata_o),
    .spi_rddata_valid_i (spi_rddata_valid_i),
    .spi_rddata_ready_o (spi_rddata_ready_o),
    .spi_rddata_mask_i  (spi_rddata_mask_i),
    .spi_rddata_i       (spi_rddata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  rsp_t          rsp_q[$];
  logic [ML-1:0] frame_q[$];
  logic          last_read = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag_ctrl, input string tag_data);
    chk(tag_ctrl, 32'({req_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, spi_wrdata_valid_o,
                       spi_rddata_ready_o, spi_wrdata_len_o}), 32'(0));
    chk(tag_data, 32'({rsp_rdata_o, spi_wrdata_o}), 32'(0));
  endtask

  task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(req_ready_o), 32'(1));
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    frame_q.push_back(w ? {1'b0, 1'b0, a, d} : {1'b0, 1'b1, a, 8'h00});
    last_read = ~w;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_wdata_i = 8'hxx;
  endtask

  task automatic accept_frame(input int exp_wait, input int stall);
    int            n = 0;
    logic [ML-1:0] exp_f;
    @(negedge clk);
    while (!spi_wrdata_valid_o && n < exp_wait + 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_latency", 32'(n), 32'(exp_wait));
    exp_f = frame_q.pop_front();
    chk("wr_frame", 32'(spi_wrdata_o), 32'(exp_f));
    chk("wr_len", 32'(spi_wrdata_len_o), 32'(15));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("wr_hold", 32'({spi_wrdata_valid_o, spi_wrdata_o}), 32'({1'b1, exp_f}));
      chk("wr_stall_req_ready", 32'(req_ready_o), 32'(0));
    end
    spi_wrdata_ready_i = 1'b1;
    @(posedge clk);
    #1;
    spi_wrdata_ready_i = 1'b0;
  endtask

  task automatic return_rd(input int delay, input logic [ML-1:0] data, input logic [ML-1:0] mask,
                           input logic expect_rsp);
    rsp_t r;
    for (int i = 0; i < delay; i++) @(negedge clk);
    @(negedge clk);
    chk("rd_ready", 32'(spi_rddata_ready_o), 32'(1));
    spi_rddata_valid_i = 1'b1;
    spi_rddata_i       = data;
    spi_rddata_mask_i  = mask;
    if (expect_rsp) begin
      r.rdata = last_read ? data[DW-1:0] : '0;
      r.err   = (mask[14:0] != 15'h7FFF);
      r.tmo   = 1'b0;
      rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    spi_rddata_valid_i = 1'b0;
    spi_rddata_i       = '0;
    spi_rddata_mask_i  = '0;
  endtask

  task automatic get_rsp(input int exp_wait, input int stall);
    int   n = 0;
    rsp_t e;
    @(negedge clk);
    while (!rsp_valid_o && n < exp_wait + 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_latency", 32'(n), 32'(exp_wait));
    e = rsp_q.pop_front();
    chk("rsp_rdata", 32'(rsp_rdata_o), 32'(e.rdata));
    chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
    chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.tmo));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", 32'({rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o}),
          32'({1'b1, e.rdata, e.err, e.tmo}));
      chk("rsp_stall_req_ready", 32'(req_ready_o), 32'(0));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: observed no completion, expected $finish before 200000 ns");
  end

  initial begin
    rst_n              = 1'b0;
    req_valid_i        = 1'b0;
    req_write_i        = 1'b0;
    req_addr_i         = '0;
    req_wdata_i        = '0;
    rsp_ready_i        = 1'b0;
    spi_wrdata_ready_i = 1'b0;
    spi_rddata_valid_i = 1'b0;
    spi_rddata_mask_i  = '0;
    spi_rddata_i       = '0;

    // Reset state, then ready one clock after release
    repeat (2) @(negedge clk);
    chk_all_zero("reset_ctrl", "reset_data");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready_o), 32'(1));
    chk("post_reset_rsp_valid", 32'(rsp_valid_o), 32'(0));

    // Write 0x15 <- 0xA5; downstream data must be ignored for writes
    send_req(1'b1, 6'h15, 8'hA5);
    accept_frame(0, 0);
    return_rd(0, 16'hBEEF, 16'h7FFF, 1'b1);
    get_rsp(0, 0);

    // Read 0x3F returning 0x3C
    send_req(1'b0, 6'h3F, 8'h77);
    accept_frame(0, 0);
    return_rd(0, 16'h003C, 16'h7FFF, 1'b1);
    get_rsp(0, 0);

    // Partial mask flags an error without a timeout
    send_req(1'b0, 6'h0A, 8'h00);
    accept_frame(0, 0);
    return_rd(0, 16'h0055, 16'h00FF, 1'b1);
    get_rsp(0, 0);

    // Data arriving on the last WAIT cycle wins over the timeout
    send_req(1'b0, 6'h01, 8'h00);
    accept_frame(0, 0);
    return_rd(TO - 1, 16'h0099, 16'hFFFF, 1'b1);
    get_rsp(0, 0);

    // Timeout after 8 WAIT cycles, then a late reply is drained
    send_req(1'b1, 6'h22, 8'h5A);
    accept_frame(0, 0);
    rsp_q.push_back('{rdata: 8'h00, err: 1'b1, tmo: 1'b1});
    get_rsp(TO, 0);
    @(negedge clk);
    chk("drain_req_ready", 32'(req_ready_o), 32'(0));
    chk("drain_rd_ready", 32'(spi_rddata_ready_o), 32'(1));
    return_rd(TO + 1, 16'h00AB, 16'hFFFF, 1'b0);
    @(negedge clk);
    chk("drain_no_rsp", 32'(rsp_valid_o), 32'(0));
    chk("drain_back_idle", 32'(req_ready_o), 32'(1));
    send_req(1'b0, 6'h2A, 8'h00);
    accept_frame(0, 0);
    return_rd(0, 16'h00C3, 16'hFFFF, 1'b1);
    get_rsp(0, 0);

    // Back-pressure on both the frame and the response
    send_req(1'b1, 6'h07, 8'h3C);
    accept_frame(0, 5);
    return_rd(0, 16'h0000, 16'h7FFF, 1'b1);
    get_rsp(0, 5);

    // Asynchronous reset while waiting for the downstream reply
    send_req(1'b0, 6'h11, 8'h00);
    accept_frame(0, 0);
    @(negedge clk);
    chk("wait_rd_ready", 32'(spi_rddata_ready_o), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_ctrl", "async_reset_data");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_req_ready", 32'(req_ready_o), 32'(1));
    chk("rerun_no_stale_rsp", 32'(rsp_valid_o), 32'(0));
    send_req(1'b1, 6'h3F, 8'hFF);
    accept_frame(0, 0);
    return_rd(0, 16'h1234, 16'h7FFF, 1'b1);
    get_rsp(0, 0);

    chk("rsp_q_empty", 32'(rsp_q.size()), 32'(0));
    chk("frame_q_empty", 32'(frame_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
